// File: rtl/serial_to_byte.sv
// serial_to_byte
//
// Deserialiser: collects a serial bit stream into 8-bit words and presents
// each completed word on a valid/ready output port. The assembled word feeds
// the or_8_way reduction stage directly.
//
// Parameters:
//   LSB_FIRST   1: first accepted bit lands in out_byte[0]
//               0: first accepted bit lands in out_byte[7]
//
// Compile-time option:
//   SERIAL_TO_BYTE_NONZERO_EN  adds the registered out_nonzero flag
//                              (OR of the word held in out_byte)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   in_bit       serial data bit
//   in_valid     in_bit is valid this cycle
//   in_ready     block accepts in_bit this cycle (combinational)
//   out_byte     assembled word (registered)
//   out_valid    out_byte holds an unconsumed word (registered)
//   out_ready    downstream takes out_byte this cycle
//   out_nonzero  OR of out_byte bits (only with SERIAL_TO_BYTE_NONZERO_EN)

module serial_to_byte #(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bit,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready
`ifdef SERIAL_TO_BYTE_NONZERO_EN
    ,
    output logic       out_nonzero
`endif
);

    logic [7:0] sh;
    logic [7:0] sh_next;
    logic [2:0] cnt;
    logic       acc;
    logic       word_done;

    // Only the final bit of a word can stall: it needs the output register
    // to be empty or emptied in this same cycle.
    always_comb begin
        in_ready  = (cnt != 3'd7) || !out_valid || out_ready;
        acc       = in_valid && in_ready;
        word_done = acc && (cnt == 3'd7);
        if (LSB_FIRST) begin
            sh_next = {in_bit, sh[7:1]};
        end else begin
            sh_next = {sh[6:0], in_bit};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sh        <= 8'h00;
            cnt       <= 3'd0;
            out_byte  <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            if (acc) begin
                sh  <= sh_next;
                // 3-bit counter wraps 7 -> 0 so the next word starts at once.
                cnt <= cnt + 3'd1;
            end
            // A completing word takes precedence over a drain: the register
            // is reloaded and out_valid stays high with no bubble.
            if (word_done) begin
                out_byte  <= sh_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef SERIAL_TO_BYTE_NONZERO_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            out_nonzero <= 1'b0;
        end else if (word_done) begin
            out_nonzero <= |sh_next;
        end
    end
`endif

endmodule

// File: tb/tb_serial_to_byte.sv
module tb_serial_to_byte;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_bit;
    logic       in_valid;
    logic       out_ready;
    logic       in_ready_lsb, in_ready_msb;
    logic [7:0] out_byte_lsb, out_byte_msb;
    logic       out_valid_lsb, out_valid_msb;
`ifdef SERIAL_TO_BYTE_NONZERO_EN
    logic       out_nonzero_lsb, out_nonzero_msb;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_to_byte #(.LSB_FIRST(1'b1)) u_dut_lsb (
        .clk       (clk),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready_lsb),
        .out_byte  (out_byte_lsb),
        .out_valid (out_valid_lsb),
        .out_ready (out_ready)
`ifdef SERIAL_TO_BYTE_NONZERO_EN
        ,
        .out_nonzero (out_nonzero_lsb)
`endif
    );

    serial_to_byte #(.LSB_FIRST(1'b0)) u_dut_msb (
        .clk       (clk),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_ready  (in_ready_msb),
        .out_byte  (out_byte_msb),
        .out_valid (out_valid_msb),
        .out_ready (out_ready)
`ifdef SERIAL_TO_BYTE_NONZERO_EN
        ,
        .out_nonzero (out_nonzero_msb)
`endif
    );

    // Reference model: list of bits received so far in the current word,
    // plus the word currently held at the output in both bit orders.
    bit         m_bits[$];
    logic [7:0] m_lsb;
    logic [7:0] m_msb;
    logic       m_valid;
    logic       seen_ready;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid_lsb", {7'd0, out_valid_lsb}, {7'd0, m_valid});
        check("out_valid_msb", {7'd0, out_valid_msb}, {7'd0, m_valid});
        check("out_byte_lsb", out_byte_lsb, m_lsb);
        check("out_byte_msb", out_byte_msb, m_msb);
`ifdef SERIAL_TO_BYTE_NONZERO_EN
        check("out_nonzero_lsb", {7'd0, out_nonzero_lsb}, {7'd0, (m_lsb != 8'h00)});
        check("out_nonzero_msb", {7'd0, out_nonzero_msb}, {7'd0, (m_msb != 8'h00)});
`endif
    endtask

    // One clock cycle: drive inputs just after an edge, check in_ready,
    // advance the model on the edge, then check registered outputs.
    task automatic cycle(input logic b, input logic v, input logic r);
        logic exp_ready;
        logic acc;
        in_bit    = b;
        in_valid  = v;
        out_ready = r;
        #1;
        exp_ready = (m_bits.size() != 7) || !m_valid || r;
        seen_ready = in_ready_lsb;
        check("in_ready_lsb", {7'd0, in_ready_lsb}, {7'd0, exp_ready});
        check("in_ready_msb", {7'd0, in_ready_msb}, {7'd0, exp_ready});
        @(posedge clk);
        acc = v && exp_ready;
        if (acc) m_bits.push_back(b);
        if (m_bits.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                m_lsb[i]     = m_bits[i];
                m_msb[7 - i] = m_bits[i];
            end
            m_bits.delete();
            m_valid = 1'b1;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    // Reset is asserted alongside a valid bit and a drain to show it wins.
    task automatic do_reset();
        reset     = 1'b1;
        in_bit    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        m_bits.delete();
        m_lsb   = 8'h00;
        m_msb   = 8'h00;
        m_valid = 1'b0;
        check_outputs();
        check("reset_in_ready", {7'd0, in_ready_lsb}, 8'h01);
    endtask

    task automatic send_byte_lsb(input logic [7:0] w, input logic r);
        for (int i = 0; i < 8; i++) cycle(w[i], 1'b1, r);
    endtask

    initial begin
        logic [7:0] pat;
        reset     = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        m_lsb     = 8'h00;
        m_msb     = 8'h00;
        m_valid   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Bits 1,0,0,0,1,1,0,0 back to back with a free output.
        pat = 8'b0011_0001;
        send_byte_lsb(pat, 1'b1);
        check("word1_byte", out_byte_lsb, 8'h31);
        check("word1_valid", {7'd0, out_valid_lsb}, 8'h01);
        cycle(1'b0, 1'b0, 1'b1);
        check("word1_one_cycle", {7'd0, out_valid_lsb}, 8'h00);

        // All-zero word.
        send_byte_lsb(8'h00, 1'b1);
        check("zero_byte", out_byte_lsb, 8'h00);
        check("zero_valid", {7'd0, out_valid_lsb}, 8'h01);
        cycle(1'b0, 1'b0, 1'b1);

        // Backpressure: 0xAA held while 0x55 stalls at its final bit.
        send_byte_lsb(8'hAA, 1'b0);
        pat = 8'h55;
        for (int i = 0; i < 7; i++) cycle(pat[i], 1'b1, 1'b0);
        check("bp_held", out_byte_lsb, 8'hAA);
        cycle(pat[7], 1'b1, 1'b0);
        check("bp_stall_ready", {7'd0, seen_ready}, 8'h00);
        check("bp_still_held", out_byte_lsb, 8'hAA);
        cycle(pat[7], 1'b1, 1'b1);
        check("bp_release", out_byte_lsb, 8'h55);
        check("bp_release_valid", {7'd0, out_valid_lsb}, 8'h01);
        cycle(1'b0, 1'b0, 1'b1);

        // Simultaneous drain and load.
        send_byte_lsb(8'h0F, 1'b0);
        pat = 8'hF0;
        for (int i = 0; i < 7; i++) cycle(pat[i], 1'b1, 1'b0);
        cycle(pat[7], 1'b1, 1'b1);
        check("dl_valid", {7'd0, out_valid_lsb}, 8'h01);
        check("dl_byte", out_byte_lsb, 8'hF0);
        cycle(1'b0, 1'b0, 1'b1);

        // Reset mid-word, then eight ones.
        send_byte_lsb(8'h3C, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0);
        do_reset();
        check("rst_byte", out_byte_lsb, 8'h00);
        send_byte_lsb(8'hFF, 1'b1);
        check("rst_next_word", out_byte_lsb, 8'hFF);
        cycle(1'b0, 1'b0, 1'b1);

        // MSB-first instance: 1 then seven zeros with idle gaps.
        for (int i = 0; i < 8; i++) begin
            cycle((i == 0) ? 1'b1 : 1'b0, 1'b1, 1'b1);
            cycle(1'b0, 1'b0, 1'b1);
            if (i == 7) begin
                // gap cycle above already drained; look at the held word
                check("msb_byte", out_byte_msb, 8'h80);
            end
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 2) != 0));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
